fifo_nibble_uart_tx: RTL and testbench

//  - Read-side consumer for the 8-deep x 4-bit nibble FIFO: pops nibbles, pairs them into bytes
//    (first pop = low nibble) and sends each byte as UART 8N1, LSB first, on one serial pin.
//  - Sits between the FIFO read port and a uo_out pin of the tt_um top level.
//  - Frees the FIFO read side from needing hand-clocked rclk/re stimulus.

---
 rtl/fifo_nibble_uart_tx_pkg.sv | 33 +++
 rtl/fifo_nibble_uart_tx_if.sv | 24 ++
 rtl/fifo_nibble_uart_tx_bit_timer.sv | 34 +++
 rtl/fifo_nibble_uart_tx.sv | 134 +++++++++++++
 tb/tb_fifo_nibble_uart_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_nibble_uart_tx_pkg.sv
// Shared definitions for the nibble-FIFO UART transmitter: data widths and the
// 3-bit binary state encoding used by the FSM and exposed on its debug port.
package fifo_tx_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_POP_LO  = 3'd1;
    localparam logic [2:0] ST_WAIT_LO = 3'd2;
    localparam logic [2:0] ST_POP_HI  = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
    localparam logic [2:0] ST_START   = 3'd5;
    localparam logic [2:0] ST_DATA    = 3'd6;
    localparam logic [2:0] ST_STOP    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_POP_LO  = ST_POP_LO,
        S_WAIT_LO = ST_WAIT_LO,
        S_POP_HI  = ST_POP_HI,
        S_WAIT_HI = ST_WAIT_HI,
        S_START   = ST_START,
        S_DATA    = ST_DATA,
        S_STOP    = ST_STOP
    } state_t;

    // The baud counter only runs while a frame is on the line.
    function automatic logic in_frame(input state_t s);
        return (s == S_START) || (s == S_DATA) || (s == S_STOP);
    endfunction

endpackage

// File: rtl/fifo_nibble_uart_tx_if.sv
// Read port of the nibble FIFO as seen by its consumer (master) and the FIFO (slave).
interface fifo_nibble_uart_tx_if;
    import fifo_tx_pkg::*;

    // Handshake: fifo_empty is the "valid" side and fifo_re the "ready/pop" side.
    // A pop is only legal while fifo_empty=0, lasts one clk, and the popped nibble
    // appears on fifo_rdata in the clk after fifo_re=1.
    logic             fifo_empty;
    logic [NIB_W-1:0] fifo_rdata;
    logic             fifo_re;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_re
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_re
    );

endinterface

// File: rtl/fifo_nibble_uart_tx_bit_timer.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and ticks on the last count of each bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_nibble_uart_tx.sv
// Pops nibble pairs from the FIFO (low nibble first) and transmits each byte as
// UART 8N1/8N2, LSB first; tx idles high.
module fifo_nibble_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    fifo_nibble_uart_tx_if.master rd_if,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done,
    output logic [BYTE_W-1:0]     tx_byte,
    output state_t                state_o
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [NIB_W-1:0]  lo_q;
    logic [NIB_W-1:0]  lo_d;
    logic [BYTE_W-1:0] tx_byte_q;
    logic [BYTE_W-1:0] tx_byte_d;
    logic [2:0]        bit_idx_q;
    logic [2:0]        bit_idx_d;

    logic tick;
    logic pop;
    logic tx_line;
    logic done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(!in_frame(state_q)),
        .tick_o   (tick)
    );

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        tx_byte_d = tx_byte_q;
        bit_idx_d = bit_idx_q;
        pop       = 1'b0;
        tx_line   = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !rd_if.fifo_empty) begin
                    state_d = S_POP_LO;
                end
            end
            S_POP_LO: begin
                pop     = 1'b1;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                lo_d    = rd_if.fifo_rdata;
                state_d = S_POP_HI;
            end
            S_POP_HI: begin
                // Stall here with the line idle until the high nibble arrives.
                if (!rd_if.fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                tx_byte_d = {rd_if.fifo_rdata, lo_q};
                state_d   = S_START;
            end
            S_START: begin
                tx_line = 1'b0;
                if (tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_byte_q[bit_idx_q];
                if (tick) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // bit_idx re-used as the stop-bit counter.
                if (tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        done      = 1'b1;
                        bit_idx_d = 3'd0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lo_q      <= '0;
            tx_byte_q <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            tx_byte_q <= tx_byte_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign rd_if.fifo_re = pop;
    assign tx            = tx_line;
    assign busy          = (state_q != S_IDLE);
    assign byte_done     = done;
    assign tx_byte       = tx_byte_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Bench for fifo_nibble_uart_tx: behavioural FIFO, serial-line decoder and byte scoreboard.
module tb_fifo_nibble_uart_tx;
    import fifo_tx_pkg::*;

    localparam int CPB   = 16;
    localparam int SB    = 1;
    localparam int FRAME = CPB * 10;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       tx;
    logic       busy;
    logic       byte_done;
    logic [7:0] tx_byte;
    state_t     state_o;

    always #5 clk = ~clk;

    fifo_nibble_uart_tx_if rd_if();

    fifo_nibble_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .rd_if    (rd_if),
        .tx       (tx),
        .busy     (busy),
        .byte_done(byte_done),
        .tx_byte  (tx_byte),
        .state_o  (state_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural FIFO ----------------
    logic [3:0] fifo_q[$];
    logic [3:0] push_q[$];
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_if.fifo_re === 1'b1 && fifo_q.size() > 0) begin
            rd_if.fifo_rdata <= fifo_q.pop_front();
        end
        while (push_q.size() > 0) begin
            fifo_q.push_back(push_q.pop_front());
        end
        rd_if.fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- scoreboard / model ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       have_lo = 1'b0;
    logic [3:0] lo_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bytes are formed from consecutive nibble pushes, first = low nibble.
    task automatic push(input logic [3:0] n, input bit to_model);
        push_q.push_back(n);
        if (to_model) begin
            if (have_lo) begin
                exp_q.push_back({n, lo_hold});
                have_lo = 1'b0;
            end else begin
                lo_hold = n;
                have_lo = 1'b1;
            end
        end
    endtask

    // ---------------- monitors ----------------
    int         re_total = 0;
    int         viol = 0;
    int         dec_err = 0;
    logic       prev_re = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] done_byte_q[$];
    int         fall_q[$];
    int         done_q[$];
    logic       dec_act = 1'b0;
    int         dec_ph;
    int         slot;
    logic [7:0] dec_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (rd_if.fifo_re === 1'b1) begin
                    re_total++;
                    if (rd_if.fifo_empty !== 1'b0 || prev_re) viol++;
                end
                if (byte_done === 1'b1) begin
                    done_q.push_back(cyc);
                    done_byte_q.push_back(tx_byte);
                end
                if (!dec_act) begin
                    if (tx === 1'b0) begin
                        dec_act  = 1'b1;
                        dec_ph   = 0;
                        dec_byte = '0;
                        fall_q.push_back(cyc);
                    end
                end else begin
                    dec_ph++;
                end
                if (dec_act && (dec_ph % CPB == CPB / 2)) begin
                    slot = dec_ph / CPB;
                    if (slot == 0) begin
                        if (tx !== 1'b0) dec_err++;
                    end else if (slot <= 8) begin
                        dec_byte[slot-1] = tx;
                    end else begin
                        if (tx !== 1'b1) dec_err++;
                        if (slot == 8 + SB) begin
                            got_q.push_back(dec_byte);
                            dec_act = 1'b0;
                        end
                    end
                end
            end else begin
                dec_act = 1'b0;
            end
            prev_re = (rd_if.fifo_re === 1'b1);
        end
    end

    // ---------------- driver / wait tasks ----------------
    task automatic wait_re(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_if.fifo_re === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_tx_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (byte_done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic sb_drain(input string tag);
        logic [7:0] e;
        check({tag, "_line_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        check({tag, "_done_count"}, 32'(done_byte_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) check({tag, "_line_byte"}, 32'(got_q.pop_front()), 32'(e));
            if (done_byte_q.size() > 0) check({tag, "_tx_byte"}, 32'(done_byte_q.pop_front()), 32'(e));
        end
        got_q.delete();
        done_byte_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [7:0] exp_byte;
        logic [9:0] exp_line;   // bit k = line level during bit slot k (start..stop)
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        bit         ok;
        int         c_re1;
        int         bad;
        int         done_at;
        int         n_done;
        logic [9:0] line;
        push(v.lo, 1'b1);
        push(v.hi, 1'b1);
        wait_re(20, ok);
        check($sformatf("v%0d_re1_seen", idx), 32'(ok), 32'd1);
        c_re1 = cyc;
        wait_re(10, ok);
        check($sformatf("v%0d_re2_seen", idx), 32'(ok), 32'd1);
        check($sformatf("v%0d_re_gap", idx), 32'(cyc - c_re1), 32'd2);
        wait_tx_low(20, ok);
        check($sformatf("v%0d_fall_seen", idx), 32'(ok), 32'd1);
        check($sformatf("v%0d_fall_latency", idx), 32'(cyc - c_re1), 32'd4);
        check($sformatf("v%0d_tx_byte", idx), 32'(tx_byte), 32'(v.exp_byte));
        bad = 0; done_at = -1; n_done = 0; line = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== v.exp_line[k / CPB]) bad++;
            if (busy !== 1'b1) bad++;
            if (k % CPB == CPB / 2) line[k / CPB] = tx;
            if (byte_done === 1'b1) begin done_at = k; n_done++; end
        end
        check($sformatf("v%0d_line_bits", idx), 32'(line), 32'(v.exp_line));
        check($sformatf("v%0d_bad_cycles", idx), 32'(bad), 32'd0);
        check($sformatf("v%0d_done_pos", idx), 32'(done_at), 32'(FRAME - 1));
        check($sformatf("v%0d_done_count", idx), 32'(n_done), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_idle_after", idx), 32'(state_o), 32'(S_IDLE));
        check($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit         ok;
        int         bad;
        int         re0;
        int         d0;
        int         f0;
        logic [3:0] n[4];

        vecs[0] = '{4'hA, 4'h5, 8'h5A, 10'h2B4};
        vecs[1] = '{4'hF, 4'hF, 8'hFF, 10'h3FE};
        vecs[2] = '{4'h0, 4'h0, 8'h00, 10'h200};
        vecs[3] = '{4'h1, 4'h8, 8'h81, 10'h302};
        vecs[4] = '{4'h3, 4'hC, 8'hC3, 10'h386};
        vecs[5] = '{4'h6, 4'h9, 8'h96, 10'h32C};

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_re", 32'(rd_if.fifo_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(byte_done), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_state", 32'(state_o), 32'(S_IDLE));

        rst_n  = 1'b1;
        enable = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || rd_if.fifo_re !== 1'b0 || busy !== 1'b0 ||
                byte_done !== 1'b0 || tx_byte !== 8'h00 || state_o !== S_IDLE) bad++;
        end
        check("empty_idle_100", 32'(bad), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        sb_drain("vec");

        // Only the low nibble present: one pop, then a stall in POP_HI.
        re0 = re_total;
        push(4'h3, 1'b1);
        wait_re(20, ok);
        check("uf_first_pop", 32'(ok), 32'd1);
        @(negedge clk);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (state_o !== S_POP_HI || tx !== 1'b1 || rd_if.fifo_re !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("uf_hold", 32'(bad), 32'd0);
        check("uf_pops_while_waiting", 32'(re_total - re0), 32'd1);
        push(4'hC, 1'b1);
        wait_done(400, ok);
        check("uf_done", 32'(ok), 32'd1);
        check("uf_tx_byte", 32'(tx_byte), 32'hC3);
        check("uf_pops", 32'(re_total - re0), 32'd2);
        sb_drain("uf");

        // Back-to-back random bytes.
        for (int r = 0; r < 3; r++) begin
            repeat (3) @(negedge clk);
            re0 = re_total; d0 = done_q.size(); f0 = fall_q.size();
            for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 1'b1);
            for (int i = 0; i < 1000 && (done_q.size() - d0) < 4; i++) @(negedge clk);
            check($sformatf("b2b%0d_frames", r), 32'(done_q.size() - d0), 32'd4);
            check($sformatf("b2b%0d_pops", r), 32'(re_total - re0), 32'd8);
            for (int j = 1; j < 4; j++) begin
                if (fall_q.size() > f0 + j && done_q.size() > d0 + j - 1) begin
                    check($sformatf("b2b%0d_gap%0d", r, j), 32'(fall_q[f0+j] - done_q[d0+j-1] - 1), 32'd5);
                end
            end
            sb_drain($sformatf("b2b%0d", r));
        end

        // enable dropped mid-frame: frame completes, no further pops until re-enabled.
        repeat (3) @(negedge clk);
        re0 = re_total; d0 = done_q.size();
        for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 1'b1);
        wait_tx_low(30, ok);
        check("en_fall_seen", 32'(ok), 32'd1);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_done(400, ok);
        check("en_first_done", 32'(ok), 32'd1);
        repeat (100) @(negedge clk);
        check("en_pops_disabled", 32'(re_total - re0), 32'd2);
        check("en_state_disabled", 32'(state_o), 32'(S_IDLE));
        check("en_frames_disabled", 32'(done_q.size() - d0), 32'd1);
        enable = 1'b1;
        wait_done(400, ok);
        check("en_second_done", 32'(ok), 32'd1);
        check("en_pops_total", 32'(re_total - re0), 32'd4);
        sb_drain("en");

        // Reset during DATA bit 3: frame abandoned, next frame uses the next pair.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) n[i] = 4'($urandom_range(0, 15));
        push(n[0], 1'b0);
        push(n[1], 1'b0);
        push(n[2], 1'b1);
        push(n[3], 1'b1);
        wait_tx_low(30, ok);
        check("rmf_fall_seen", 32'(ok), 32'd1);
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        check("rmf_in_data", 32'(state_o), 32'(S_DATA));
        rst_n = 1'b0;
        #1;
        check("rmf_tx_high", 32'(tx), 32'd1);
        check("rmf_state_idle", 32'(state_o), 32'(S_IDLE));
        check("rmf_busy_low", 32'(busy), 32'd0);
        check("rmf_tx_byte_cleared", 32'(tx_byte), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_done(400, ok);
        check("rmf_done", 32'(ok), 32'd1);
        check("rmf_tx_byte", 32'(tx_byte), 32'({n[3], n[2]}));
        sb_drain("rmf");

        check("re_rules", 32'(viol), 32'd0);
        check("frame_errors", 32'(dec_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
